// File: rtl/test_decompressor.sv
`default_nettype none
// ============================================================================
// Module      : test_decompressor
// Description : Expands a 4-symbol (8-bit) compressed seed through an 8-bit
//               Fibonacci LFSR into a 2N+1 bit test pattern {ci, b, a} for an
//               N-bit adder under test, with a valid/ready pattern handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module test_decompressor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   chan_in,
    input  logic         chan_valid,
    output logic         chan_ready,
    input  logic         flush,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         ci,
    output logic         pat_valid,
    input  logic         pat_ready,
    output logic [15:0]  pat_cnt,
    output logic         busy
);

    localparam int c_PAT_W = 2 * N + 1;
    localparam int c_CNT_W = $clog2(c_PAT_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_PAT_W - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_sym_idx;
    logic [7:0]           r_seed;
    logic [7:0]           r_lfsr;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [2*N-1:0]       r_pat_sr;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic                 r_ci;
    logic                 r_pat_valid;
    logic [15:0]          r_pat_cnt;

    logic                 w_accept;
    logic                 w_seed_done;
    logic                 w_last_bit;
    logic                 w_take;
    logic                 w_lfsr_bit;
    logic                 w_lfsr_fb;
    logic [c_PAT_W-1:0]   w_full_pat;

    // Qualified events; flush overrides every one of them on the same edge.
    assign w_accept    = (r_state == ST_LOAD) && chan_valid && !flush;
    assign w_seed_done = w_accept && (r_sym_idx == 2'd3);
    assign w_last_bit  = (r_state == ST_EXPAND) && (r_bit_cnt == c_LAST_BIT) && !flush;
    assign w_take      = (r_state == ST_HOLD) && pat_ready && !flush;

    assign w_lfsr_bit  = r_lfsr[0];
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[4];
    // Generated bit j sits at position j once the final bit is appended.
    assign w_full_pat  = {w_lfsr_bit, r_pat_sr};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (w_seed_done) w_state_nxt = ST_EXPAND;
                ST_EXPAND: if (w_last_bit)  w_state_nxt = ST_HOLD;
                ST_HOLD:   if (w_take)      w_state_nxt = ST_LOAD;
                default:   w_state_nxt = ST_LOAD;
            endcase
        end
    end

    // Seed capture, LFSR expansion, pattern register and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_idx   <= 2'd0;
            r_seed      <= 8'd0;
            r_lfsr      <= 8'd0;
            r_bit_cnt   <= '0;
            r_pat_sr    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ci        <= 1'b0;
            r_pat_valid <= 1'b0;
            r_pat_cnt   <= 16'd0;
        end else if (flush) begin
            r_sym_idx   <= 2'd0;
            r_pat_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_seed[{r_sym_idx, 1'b0} +: 2] <= chan_in;
                r_sym_idx <= r_sym_idx + 2'd1;
            end
            if (w_seed_done) begin
                r_lfsr    <= {chan_in, r_seed[5:0]};
                r_bit_cnt <= '0;
            end
            if (r_state == ST_EXPAND) begin
                r_lfsr    <= {w_lfsr_fb, r_lfsr[7:1]};
                r_pat_sr  <= {w_lfsr_bit, r_pat_sr[2*N-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_last_bit) begin
                r_a         <= w_full_pat[N-1:0];
                r_b         <= w_full_pat[2*N-1:N];
                r_ci        <= w_full_pat[2*N];
                r_pat_valid <= 1'b1;
            end
            if (w_take) begin
                r_pat_valid <= 1'b0;
                r_pat_cnt   <= r_pat_cnt + 16'd1;
                r_sym_idx   <= 2'd0;
            end
        end
    end

    assign chan_ready = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_EXPAND) || (r_state == ST_HOLD);
    assign a          = r_a;
    assign b          = r_b;
    assign ci         = r_ci;
    assign pat_valid  = r_pat_valid;
    assign pat_cnt    = r_pat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_decompressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_decompressor
// Description : Scoreboard bench for test_decompressor: directed seeds with
//               hand-derived patterns, hold/flush/reset/wrap scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_decompressor;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic [1:0]   chan_in;
    logic         chan_valid;
    logic         chan_ready;
    logic         flush;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         pat_valid;
    logic         pat_ready;
    logic [15:0]  pat_cnt;
    logic         busy;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ci;
        logic [15:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_bad;
    logic [15:0] exp_cnt;
    logic        pv_prev;

    test_decompressor #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chan_in    (chan_in),
        .chan_valid (chan_valid),
        .chan_ready (chan_ready),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .ci         (ci),
        .pat_valid  (pat_valid),
        .pat_ready  (pat_ready),
        .pat_cnt    (pat_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each rising pat_valid pops one expected pattern.
    always @(negedge clk) begin
        if (rst_n && pat_valid && !pv_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pattern", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_a", 32'(a), 32'(e.a));
                chk("sb_b", 32'(b), 32'(e.b));
                chk("sb_ci", 32'(ci), 32'(e.ci));
                chk("sb_cnt", 32'(pat_cnt), 32'(e.cnt));
            end
        end
        pv_prev <= rst_n ? pat_valid : 1'b0;
    end

    task automatic load_seed(input logic [7:0] seed);
        for (int k = 0; k < 4; k++) begin
            chan_in    = seed[2*k +: 2];
            chan_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        chan_valid = 1'b0;
    endtask

    // Issue a seed, queue its expected pattern, and check 33-edge latency.
    task automatic run_seed(input logic [7:0] seed, input logic [N-1:0] ea,
                            input logic [N-1:0] eb, input logic eci);
        int lat;
        exp_t e;
        e.a = ea; e.b = eb; e.ci = eci; e.cnt = exp_cnt;
        sb_q.push_back(e);
        load_seed(seed);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (pat_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd33);
        @(negedge clk);
    endtask

    task automatic handshake();
        pat_ready = 1'b1;
        @(posedge clk);
        #1;
        pat_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("hs_valid", 32'(pat_valid), 32'd0);
        chk("hs_load", 32'(chan_ready), 32'd1);
        chk("hs_cnt", 32'(pat_cnt), 32'(exp_cnt));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_ci", 32'(ci), 32'd0);
        chk("rst_valid", 32'(pat_valid), 32'd0);
        chk("rst_cnt", 32'(pat_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(chan_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; exp_cnt = 16'd0; pv_prev = 1'b0;
        rst_n = 1'b0; chan_in = 2'd0; chan_valid = 1'b0; flush = 1'b0; pat_ready = 1'b0;
        #12;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Seed 0x01, then hold for 10 cycles with stray channel traffic.
        run_seed(8'h01, 16'h7101, 16'h03A4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chan_in = 2'(i); chan_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_a", 32'(a), 32'h7101);
            chk("hold_b", 32'(b), 32'h03A4);
            chk("hold_ci", 32'(ci), 32'd1);
            chk("hold_valid", 32'(pat_valid), 32'd1);
            chk("hold_chan_ready", 32'(chan_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        chan_valid = 1'b0;
        handshake();

        // All-zero seed (also shows no stray symbol was stored during HOLD).
        run_seed(8'h00, 16'h0000, 16'h0000, 1'b0);
        handshake();

        // Partial seed then flush: index must restart at symbol 0.
        chan_in = 2'd3; chan_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chan_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_cnt", 32'(pat_cnt), 32'(exp_cnt));
        chk("flush_busy", 32'(busy), 32'd0);
        run_seed(8'h01, 16'h7101, 16'h03A4, 1'b1);
        handshake();

        // Asynchronous reset in the middle of EXPAND.
        load_seed(8'h01);
        repeat (19) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seed(8'h01, 16'h7101, 16'h03A4, 1'b1);
        handshake();

        // Counter wrap from 0xFFFF.
        force dut.r_pat_cnt = 16'hFFFF;
        #1;
        release dut.r_pat_cnt;
        exp_cnt = 16'hFFFF;
        run_seed(8'h00, 16'h0000, 16'h0000, 1'b0);
        handshake();
        chk("wrap_cnt", 32'(pat_cnt), 32'h0000);

        // Flush together with pat_ready in HOLD: no increment, outputs held.
        run_seed(8'h01, 16'h7101, 16'h03A4, 1'b1);
        flush = 1'b1; pat_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; pat_ready = 1'b0;
        chk("fr_cnt", 32'(pat_cnt), 32'(exp_cnt));
        chk("fr_valid", 32'(pat_valid), 32'd0);
        chk("fr_busy", 32'(busy), 32'd0);
        chk("fr_a", 32'(a), 32'h7101);
        chk("fr_b", 32'(b), 32'h03A4);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/test_decompressor.md
TEST_DECOMPRESSOR -- requirements
Module: test_decompressor

Interface
REQ-001: Parameter N, default 16, is the operand width of the adder under test; the generated pattern is 2N+1 bits, and all concrete values below assume N=16.
REQ-002: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: chan_in  input  2  compressed seed symbol from the tester channel.
REQ-005: chan_valid  input  1  chan_in holds a valid symbol.
REQ-006: chan_ready  output  1  the block accepts a symbol this cycle.
REQ-007: flush  input  1  synchronous abort; discards the current seed or pattern.
REQ-008: a  output  N  operand A for the adder under test.
REQ-009: b  output  N  operand B for the adder under test.
REQ-010: ci  output  1  carry-in for the adder under test.
REQ-011: pat_valid  output  1  a, b and ci form a complete pattern.
REQ-012: pat_ready  input  1  the consumer takes the pattern.
REQ-013: pat_cnt  output  16  count of delivered patterns.
REQ-014: busy  output  1  high in EXPAND or HOLD.

Function
REQ-015: The FSM SHALL have exactly three states: LOAD, EXPAND and HOLD.
REQ-016: In LOAD, chan_ready=1; in EXPAND and HOLD, chan_ready=0.
REQ-017: A symbol is accepted when chan_valid=1 and chan_ready=1 on the same edge; accepted symbol k (k=0..3) SHALL be written to seed[2k+1:2k].
REQ-018: On the edge that accepts symbol 3, the FSM SHALL load the 8-bit LFSR with the complete seed, clear the bit counter, and enter EXPAND.
REQ-019: LFSR definition (Fibonacci, right shift), per EXPAND cycle:
  - output bit = s[0];
  - feedback f = s[0]^s[2]^s[3]^s[4];
  - next state = {f, s[7:1]}.
REQ-020: EXPAND SHALL last exactly 2N+1 = 33 cycles; generated bit j (j=0..32) goes to internal pattern bit j.
REQ-021: Pattern mapping: bits 0..N-1 -> a[N-1:0]; bits N..2N-1 -> b[N-1:0]; bit 2N -> ci.
REQ-022: On the 33rd EXPAND edge, a, b and ci SHALL update together, pat_valid SHALL go to 1, and the FSM SHALL enter HOLD.
REQ-023: Outside the update of REQ-022, a, b and ci SHALL keep their values.
REQ-024: Latency: pat_valid SHALL rise exactly 33 clock edges after the edge that accepts symbol 3.
REQ-025: In HOLD, a, b, ci and pat_valid SHALL stay stable until pat_ready=1.
REQ-026: On the HOLD edge with pat_ready=1:
  - pat_valid goes to 0;
  - pat_cnt increments, wrapping 0xFFFF to 0x0000;
  - the FSM returns to LOAD with the symbol index cleared.
REQ-027: pat_ready is ignored outside HOLD.
REQ-028: An all-zero seed SHALL be legal and SHALL produce a=0, b=0, ci=0 without lock-up handling.
REQ-029: flush=1 SHALL, on that edge, in any state:
  - return the FSM to LOAD;
  - clear the symbol index and pat_valid;
  - hold a, b, ci and pat_cnt.
REQ-030: flush has priority over a symbol accept or a pattern handshake on the same edge; neither takes effect and pat_cnt does not increment.
REQ-031: chan_valid in EXPAND or HOLD SHALL be ignored, and no symbol is stored.
REQ-032: busy SHALL be 1 exactly when the state is EXPAND or HOLD.

Reset
REQ-033: rst_n=0 SHALL immediately force:
  - state to LOAD, with symbol index, bit counter, seed and LFSR cleared;
  - a=0, b=0, ci=0;
  - pat_valid=0, pat_cnt=0, busy=0;
  - chan_ready=1.
REQ-034: Reset asserted during EXPAND or HOLD SHALL abandon the pattern; after release, 4 new symbols are required before the next pattern.

Verification
REQ-035: Seed 0x01 (symbols 1,0,0,0) -> 33 cycles later pat_valid=1 with a=0x7101, b=0x03A4, ci=1.
REQ-036: Seed 0x00 -> pattern a=0x0000, b=0x0000, ci=0; pat_cnt goes 0 to 1 after the handshake.
REQ-037: Hold pat_ready=0 for 10 cycles in HOLD -> a, b, ci stable, chan_ready=0, and extra chan_valid pulses are ignored. Then pat_ready=1 -> next cycle LOAD, pat_cnt +1.
REQ-038: Accept 2 symbols, then pulse flush -> symbol index cleared. Four new symbols of seed 0x01 -> same result as REQ-035, and pat_cnt unchanged by the flush.
REQ-039: Assert rst_n=0 at EXPAND cycle 20 -> all outputs at reset values immediately. After release, seed 0x01 reproduces the REQ-035 pattern.
REQ-040: Preload pat_cnt to 0xFFFF via 65535 handshakes (or force) -> the next handshake gives pat_cnt=0x0000. flush and pat_ready together in HOLD -> no increment.
